// File: rtl/rx_data_sampling.sv
// UART RX oversampling front end: synchronizes rx_in, counts edges at the prescale rate
// and majority-votes three mid-bit samples. Define RX_NOISE_FLAG_EN to add noise_flag.
module rx_data_sampling #(
  parameter int unsigned PRESCALE_W  = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  dat_samp_en,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  bit_done,
  output logic [PRESCALE_W-1:0] edge_cnt
`ifdef RX_NOISE_FLAG_EN
  ,
  output logic                  noise_flag
`endif
);

  typedef logic [PRESCALE_W-1:0] cnt_t;

  localparam cnt_t P8  = cnt_t'(8);
  localparam cnt_t P16 = cnt_t'(16);
  localparam cnt_t P32 = cnt_t'(32);

  function automatic cnt_t legal_p(input cnt_t p);
    return (p == P16 || p == P32) ? p : P8;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_sync;
  logic                   en_d;
  logic                   start;
  cnt_t                   p_lat;
  cnt_t                   cur_p;
  cnt_t                   half;
  cnt_t                   last_edge;
  cnt_t                   pre_last_edge;
  cnt_t                   s0_edge;
  cnt_t                   vote_edge;
  logic                   s0;
  logic                   s1;
  logic                   vote;

  assign rx_sync = sync_q[SYNC_STAGES-1];

  // On the enable cycle itself the latch is not yet loaded, so use the incoming value.
  always_comb begin
    start         = dat_samp_en & ~en_d;
    cur_p         = start ? legal_p(prescale) : p_lat;
    half          = cur_p >> 1;
    last_edge     = cur_p - cnt_t'(1);
    pre_last_edge = cur_p - cnt_t'(2);
    s0_edge       = half - cnt_t'(1);
    vote_edge     = half + cnt_t'(1);
    vote          = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
    end
  end

  // Strobes are registered one edge early so they line up with the counter value they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_d         <= 1'b0;
      p_lat        <= P8;
      edge_cnt     <= '0;
      bit_done     <= 1'b0;
      sample_valid <= 1'b0;
      sampled_bit  <= 1'b1;
      s0           <= 1'b1;
      s1           <= 1'b1;
`ifdef RX_NOISE_FLAG_EN
      noise_flag   <= 1'b0;
`endif
    end else begin
      en_d         <= dat_samp_en;
      bit_done     <= 1'b0;
      sample_valid <= 1'b0;
`ifdef RX_NOISE_FLAG_EN
      noise_flag   <= 1'b0;
`endif
      if (start) begin
        p_lat <= legal_p(prescale);
      end
      if (!dat_samp_en) begin
        edge_cnt <= '0;
        s0       <= 1'b1;
        s1       <= 1'b1;
      end else begin
        edge_cnt <= (edge_cnt == last_edge) ? '0 : edge_cnt + cnt_t'(1);
        bit_done <= (edge_cnt == pre_last_edge);
        if (edge_cnt == s0_edge) begin
          s0 <= rx_sync;
        end
        if (edge_cnt == half) begin
          s1 <= rx_sync;
        end
        if (edge_cnt == vote_edge) begin
          sampled_bit  <= vote;
          sample_valid <= 1'b1;
`ifdef RX_NOISE_FLAG_EN
          noise_flag   <= ~((s0 == s1) && (s1 == rx_sync));
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_data_sampling.sv
// Randomized bench for rx_data_sampling against a run-length based reference model.
module tb_rx_data_sampling;

  localparam int unsigned PW = 6;
  localparam int unsigned SS = 2;
  localparam int unsigned SEG_CYCLES = 1400;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          rx_in = 1'b1;
  logic [PW-1:0] prescale = PW'(8);
  logic          dat_samp_en = 1'b0;
  logic          sampled_bit;
  logic          sample_valid;
  logic          bit_done;
  logic [PW-1:0] edge_cnt;
`ifdef RX_NOISE_FLAG_EN
  logic          noise_flag;
`endif

  always #5 clk = ~clk;

  rx_data_sampling #(
    .PRESCALE_W (PW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_in       (rx_in),
    .prescale    (prescale),
    .dat_samp_en (dat_samp_en),
    .sampled_bit (sampled_bit),
    .sample_valid(sample_valid),
    .bit_done    (bit_done),
    .edge_cnt    (edge_cnt)
`ifdef RX_NOISE_FLAG_EN
    ,
    .noise_flag  (noise_flag)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
  endtask

  // Model state: inputs per period since reset release, length of the current enabled run
  bit          en_h[4096];
  bit          rx_h[4096];
  int          k;
  int unsigned run_len;
  int unsigned run_p;
  bit          m_sb;
  bit          rx_level;
  int unsigned base_p;

  function automatic int unsigned legal(input int unsigned p);
    return (p == 16 || p == 32) ? p : 8;
  endfunction

  function automatic bit rx_sync_at(input int j);
    return (j < int'(SS)) ? 1'b1 : rx_h[j - int'(SS)];
  endfunction

  task automatic check_period();
    int unsigned p, e, m;
    bit exp_sv, exp_bd, exp_nf, a, b, c;
    p      = (run_len > 0) ? run_p : 8;
    e      = run_len % p;
    m      = p / 2;
    exp_bd = (run_len > 0) && (e == p - 1);
    exp_sv = (run_len > 0) && (e == m + 2);
    exp_nf = 1'b0;
    if (exp_sv) begin
      a      = rx_sync_at(k - 3);
      b      = rx_sync_at(k - 2);
      c      = rx_sync_at(k - 1);
      m_sb   = (a & b) | (a & c) | (b & c);
      exp_nf = !(a == b && b == c);
    end
    check_eq("edge_cnt", 32'(edge_cnt), e);
    check_eq("bit_done", 32'(bit_done), 32'(exp_bd));
    check_eq("sample_valid", 32'(sample_valid), 32'(exp_sv));
    check_eq("sampled_bit", 32'(sampled_bit), 32'(m_sb));
`ifdef RX_NOISE_FLAG_EN
    check_eq("noise_flag", 32'(noise_flag), 32'(exp_nf));
`else
    if (exp_nf) m_sb = m_sb;
`endif
  endtask

  task automatic drive_inputs();
    int unsigned drop_div;
    drop_div = (base_p == 32) ? 120 : 48;
    if (dat_samp_en) begin
      if ($urandom % drop_div == 0) dat_samp_en = 1'b0;
    end else if ($urandom % 3 == 0) begin
      dat_samp_en = 1'b1;
    end
    if ($urandom % 10 == 0) begin
      case ($urandom % 6)
        0, 1, 2: prescale = PW'(base_p);
        3:       prescale = PW'(16);
        4:       prescale = PW'(32);
        default: prescale = PW'($urandom % 64);
      endcase
    end
    if ($urandom % 12 == 0) rx_level = ~rx_level;
    rx_in = rx_level ^ ($urandom % 14 == 0);
    en_h[k] = dat_samp_en;
    rx_h[k] = rx_in;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (en_h[k]) begin
      if (run_len == 0) run_p = legal(32'(prescale));
      run_len++;
    end else begin
      run_len = 0;
    end
    k++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check_eq("rst_edge_cnt", 32'(edge_cnt), 0);
    check_eq("rst_sample_valid", 32'(sample_valid), 0);
    check_eq("rst_bit_done", 32'(bit_done), 0);
    check_eq("rst_sampled_bit", 32'(sampled_bit), 1);
`ifdef RX_NOISE_FLAG_EN
    check_eq("rst_noise_flag", 32'(noise_flag), 0);
`endif
    dat_samp_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n  = 1'b1;
    rx_level = 1'b1;
    k        = 0;
    run_len  = 0;
    run_p    = 8;
    m_sb     = 1'b1;
  endtask

  initial begin
    #2;
    for (int seg = 0; seg < 6; seg++) begin
      case (seg % 4)
        0:       base_p = 8;
        1:       base_p = 16;
        2:       base_p = 32;
        default: base_p = 12;
      endcase
      prescale = PW'(base_p);
      do_reset();
      for (int i = 0; i < int'(SEG_CYCLES); i++) begin
        check_period();
        drive_inputs();
        advance();
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
